// File: rtl/prn_pkg.sv
// Shared PRBS10 definitions for the PRN generator / stream checker pair.
//   PRN_LFSR_W : reference register width (x^10 term)
//   PRN_TAP    : second feedback tap, 1-based (x^7 term)
//   state_t    : checker FSM encoding, also exported on state_dbg
package prn_pkg;

  localparam int unsigned PRN_LFSR_W = 10;
  localparam int unsigned PRN_TAP    = 7;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_VERIFY = 2'b01,
    ST_LOCKED = 2'b10,
    ST_BAD    = 2'b11
  } state_t;

endpackage

// File: rtl/prn_ref_lfsr.sv
// Reference PRBS shift register for the stream checker.
// Ports:
//   clk, rst  : bit clock, asynchronous active-low reset
//   shift_en  : advance the register by one bit
//   load_sel  : 0 = shift in din (seeding), 1 = shift in p_c (free-run)
//   din       : recovered data bit
//   p_c       : predicted next bit from the current register contents
//   zero_c    : register would be all zero after shifting din in
module prn_ref_lfsr #(
  parameter int unsigned LFSR_W = 10,
  parameter int unsigned TAP    = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic shift_en,
  input  logic load_sel,
  input  logic din,
  output logic p_c,
  output logic zero_c
);

  logic [LFSR_W-1:0] s_q;
  logic              nb;

  // Prediction: b[n] = b[n-LFSR_W] ^ b[n-TAP]
  assign p_c = s_q[LFSR_W-1] ^ s_q[TAP-1];

  assign nb = load_sel ? p_c : din;

  // Zero test on the post-shift seed value, used at the end of a fill
  assign zero_c = ({s_q[LFSR_W-2:0], din} == '0);

  // Reference register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q <= '0;
    end else if (shift_en) begin
      s_q <= {s_q[LFSR_W-2:0], nb};
    end
  end

endmodule

// File: rtl/prn_stream_checker.sv
// PRBS10 stream checker: self-synchronises to the recovered bit stream,
// then counts bit errors and detects loss of lock.
// Ports:
//   clk, rst   : bit clock, asynchronous active-low reset
//   din        : recovered data bit
//   din_valid  : din qualifier; nothing advances when low
//   clr_cnt    : synchronous clear of err_count (wins over a same-cycle error)
//   locked     : reference aligned to the stream
//   err_pulse  : one-cycle pulse per mismatching bit while locked
//   err_count  : saturating error total
//   state_dbg  : current FSM state encoding
module prn_stream_checker
  import prn_pkg::*;
#(
  parameter int unsigned LFSR_W     = PRN_LFSR_W,
  parameter int unsigned TAP        = PRN_TAP,
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned WIN_LEN    = 64,
  parameter int unsigned LOL_THRESH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state_dbg
);

  localparam int unsigned FILL_W  = $clog2(LFSR_W + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned WIN_W   = $clog2(WIN_LEN + 1);

  state_t             state_q, state_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [WIN_W-1:0]   werr_q, werr_d;
  logic [WIN_W-1:0]   werr_sum;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic               locked_q;
  logic               err_pulse_q;
  logic               err_d;
  logic               shift_en;
  logic               load_sel;
  logic               p_c;
  logic               zero_c;
  logic               mismatch;

  prn_ref_lfsr #(
    .LFSR_W (LFSR_W),
    .TAP    (TAP)
  ) u_ref (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .load_sel (load_sel),
    .din      (din),
    .p_c      (p_c),
    .zero_c   (zero_c)
  );

  assign mismatch = din ^ p_c;

  // Next-state, counters and reference control
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    match_d  = match_q;
    win_d    = win_q;
    werr_d   = werr_q;
    werr_sum = werr_q;
    shift_en = 1'b0;
    load_sel = 1'b0;
    err_d    = 1'b0;

    if (din_valid) begin
      shift_en = 1'b1;
      unique case (state_q)
        ST_HUNT: begin
          if (fill_q == FILL_W'(LFSR_W - 1)) begin
            fill_d = '0;
            // An all-zero seed is a fixed point of the LFSR: never accept it
            if (!zero_c) begin
              state_d = ST_VERIFY;
              match_d = '0;
            end
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        ST_VERIFY: begin
          if (mismatch) begin
            state_d = ST_HUNT;
            fill_d  = '0;
          end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
            state_d = ST_LOCKED;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end
        ST_LOCKED: begin
          // Free-run on the prediction so input errors do not corrupt the reference
          load_sel = 1'b1;
          err_d    = mismatch;
          werr_sum = werr_q + WIN_W'(mismatch);
          if (win_q == WIN_W'(WIN_LEN - 1)) begin
            win_d  = '0;
            werr_d = '0;
            if (werr_sum >= WIN_W'(LOL_THRESH)) begin
              state_d = ST_HUNT;
              fill_d  = '0;
            end
          end else begin
            win_d  = win_q + WIN_W'(1);
            werr_d = werr_sum;
          end
        end
        default: begin
          state_d = ST_HUNT;
          fill_d  = '0;
        end
      endcase
    end

    // Clear wins over a coincident error; otherwise saturate at all-ones
    if (clr_cnt) begin
      err_count_d = '0;
    end else if (err_d && (err_count_q != '1)) begin
      err_count_d = err_count_q + CNT_W'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State, counters and registered status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HUNT;
      fill_q      <= '0;
      match_q     <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      err_count_q <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_q       <= win_d;
      werr_q      <= werr_d;
      err_count_q <= err_count_d;
      locked_q    <= (state_d == ST_LOCKED);
      err_pulse_q <= err_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_prn_stream_checker.sv
// Self-checking bench for prn_stream_checker: directed phases plus a random
// phase, compared against a bit-history reference model after every clock.
module tb_prn_stream_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic        din_valid;
  logic        clr_cnt;
  logic        locked, locked4;
  logic        err_pulse, err_pulse4;
  logic [15:0] err_count;
  logic [3:0]  err_count4;
  logic [1:0]  state_dbg, state_dbg4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prn_stream_checker dut (
    .clk (clk), .rst (rst), .din (din), .din_valid (din_valid), .clr_cnt (clr_cnt),
    .locked (locked), .err_pulse (err_pulse), .err_count (err_count), .state_dbg (state_dbg)
  );

  // Narrow counter instance for the saturation boundary
  prn_stream_checker #(.CNT_W(4)) dut4 (
    .clk (clk), .rst (rst), .din (din), .din_valid (din_valid), .clr_cnt (clr_cnt),
    .locked (locked4), .err_pulse (err_pulse4), .err_count (err_count4), .state_dbg (state_dbg4)
  );

  // ---------------- reference model ----------------
  // The reference sequence is kept as a history of bits; prediction is the
  // PRBS10 recurrence b[n] = b[n-10] ^ b[n-7].
  bit hist[$];
  int m_mode;   // 0 hunt, 1 verify, 2 locked
  int m_fill, m_match, m_win, m_werr, m_err;
  bit m_pulse;

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < 10; i++) hist.push_back(1'b0);
    m_mode = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0; m_err = 0; m_pulse = 1'b0;
  endfunction

  function automatic bit model_pred();
    return hist[hist.size()-10] ^ hist[hist.size()-7];
  endfunction

  function automatic void model_step(bit d, bit v, bit c);
    bit pr;
    bit all_zero;
    m_pulse = 1'b0;
    if (v) begin
      pr = model_pred();
      if (m_mode == 0) begin
        hist.push_back(d);
        m_fill++;
        if (m_fill == 10) begin
          m_fill = 0;
          all_zero = 1'b1;
          for (int i = 1; i <= 10; i++) if (hist[hist.size()-i]) all_zero = 1'b0;
          if (!all_zero) begin m_mode = 1; m_match = 0; end
        end
      end else if (m_mode == 1) begin
        hist.push_back(d);
        if (pr != d) begin
          m_mode = 0; m_fill = 0;
        end else begin
          m_match++;
          if (m_match == 16) begin m_mode = 2; m_win = 0; m_werr = 0; end
        end
      end else begin
        hist.push_back(pr);
        if (pr != d) begin m_pulse = 1'b1; m_err++; m_werr++; end
        m_win++;
        if (m_win == 64) begin
          if (m_werr >= 8) begin m_mode = 0; m_fill = 0; end
          m_win = 0; m_werr = 0;
        end
      end
      while (hist.size() > 20) void'(hist.pop_front());
    end
    if (c) m_err = 0;
  endfunction

  function automatic int sat(int v, int m);
    return (v > m) ? m : v;
  endfunction

  // ---------------- PRBS10 source, seed 10'h3FF ----------------
  bit gq[$];

  function automatic bit prbs_next();
    bit b;
    if (gq.size() < 10) b = 1'b1;
    else b = gq[gq.size()-10] ^ gq[gq.size()-7];
    gq.push_back(b);
    if (gq.size() > 20) void'(gq.pop_front());
    return b;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "_locked"},  32'(locked),     32'(m_mode == 2));
    chk({tag, "_state"},   32'(state_dbg),  32'(m_mode));
    chk({tag, "_pulse"},   32'(err_pulse),  32'(m_pulse));
    chk({tag, "_count"},   32'(err_count),  32'(sat(m_err, 65535)));
    chk({tag, "_count4"},  32'(err_count4), 32'(sat(m_err, 15)));
  endtask

  task automatic step(bit d, bit v, bit c);
    din = d; din_valid = v; clr_cnt = c;
    model_step(d, v, c);
    @(posedge clk); #1;
    check_all("cyc");
  endtask

  task automatic clean();
    step(prbs_next(), 1'b1, 1'b0);
  endtask

  task automatic flip();
    bit b;
    b = prbs_next();
    step(~b, 1'b1, 1'b0);
  endtask

  task automatic reset_pulse();
    rst = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
    #1;
    model_reset();
    check_all("rst_now");
    for (int i = 0; i < 3; i++) begin
      din = 1'($urandom);
      @(posedge clk); #1;
      check_all("rst_hold");
    end
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int nv;
    int pulses;
    bit b, v, c;

    rst = 1'b0; din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
    model_reset();

    // T1: reset with random din
    for (int i = 0; i < 5; i++) begin
      din = 1'($urandom);
      @(posedge clk); #1;
      check_all("t1");
    end
    rst = 1'b1;

    // T2: clean lock from seed 3FF, 2000 bits
    for (int i = 1; i <= 2000; i++) begin
      clean();
      if (i == 9)  chk("t2_hunt",       32'(state_dbg), 32'd0);
      if (i == 10) chk("t2_verify",     32'(state_dbg), 32'd1);
      if (i == 25) chk("t2_not_locked", 32'(locked),    32'd0);
      if (i == 26) chk("t2_locked",     32'(locked),    32'd1);
    end
    chk("t2_err", 32'(err_count), 32'd0);

    // T3: single error while locked
    flip();
    chk("t3_pulse", 32'(err_pulse), 32'd1);
    chk("t3_count", 32'(err_count), 32'd1);
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      clean();
      if (err_pulse) pulses++;
    end
    chk("t3_no_more_pulses", 32'(pulses), 32'd0);
    chk("t3_locked", 32'(locked), 32'd1);

    // T4: 8 errors inside one window -> loss of lock and relock
    step(prbs_next(), 1'b1, 1'b1);
    for (int k = 0; k < 64 && m_win != 0; k++) clean();
    for (int j = 0; j < 16; j++) begin
      if (j % 2 == 0) flip(); else clean();
    end
    n = 0;
    while (locked && n < 80) begin clean(); n++; end
    chk("t4_lol_pos", 32'(n), 32'd48);
    chk("t4_count_kept", 32'(err_count), 32'd8);
    n = 0;
    while (!locked && n < 60) begin clean(); n++; end
    chk("t4_relock", 32'(n), 32'd26);
    chk("t4_count_after", 32'(err_count), 32'd8);

    // T5: all-zero stream never leaves HUNT
    reset_pulse();
    for (int i = 0; i < 500; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("t5_state", 32'(state_dbg), 32'd0);
    end
    chk("t5_locked", 32'(locked), 32'd0);

    // T6a: gaps in din_valid, lock on 26th valid bit
    reset_pulse();
    gq.delete();
    nv = 0;
    for (int i = 0; i < 400; i++) begin
      v = ((i % 2) == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      b = v ? prbs_next() : 1'($urandom);
      step(b, v, 1'b0);
      if (v) begin
        nv++;
        if (nv == 25) chk("t6_gap_not_locked", 32'(locked), 32'd0);
        if (nv == 26) begin
          chk("t6_gap_locked", 32'(locked), 32'd1);
          break;
        end
      end
    end
    chk("t6_gap_bits", 32'(nv), 32'd26);

    // T6b: clr_cnt coincident with an error
    for (int i = 0; i < 5; i++) clean();
    flip();
    chk("t6_pre_clr", 32'(err_count), 32'd1);
    for (int i = 0; i < 5; i++) clean();
    b = prbs_next();
    step(~b, 1'b1, 1'b1);
    chk("t6_clr_count", 32'(err_count), 32'd0);
    chk("t6_clr_pulse", 32'(err_pulse), 32'd1);

    // T6c: saturation of the 4-bit counter
    for (int e = 0; e < 20; e++) begin
      flip();
      for (int i = 0; i < 69; i++) clean();
    end
    chk("t6_sat16", 32'(err_count), 32'd20);
    chk("t6_sat4",  32'(err_count4), 32'hF);
    chk("t6_sat_locked", 32'(locked), 32'd1);

    // T6d: reset while locked, then reacquire
    reset_pulse();
    chk("t6_rst_count", 32'(err_count), 32'd0);
    for (int i = 0; i < 26; i++) clean();
    chk("t6_reacq", 32'(locked), 32'd1);

    // Random phase: gaps, sparse errors, occasional clears
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 499) == 0);
      if (v) begin
        b = prbs_next();
        if ($urandom_range(0, 29) == 0) b = ~b;
      end else begin
        b = 1'($urandom);
      end
      step(b, v, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
